// File: rtl/down_count_timer.sv
// Loadable down-counter/timer: load over valid/ready, arm, start, decrement once per
// prescaled tick, and pulse done at terminal count (one-shot or auto-reload).
module down_count_timer #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_value,
  input  logic [PRESC_W-1:0] load_prescale,
  input  logic               reload_en,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               armed,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     count_r;
  logic [WIDTH-1:0]     reload_r;
  logic [PRESC_W-1:0]   presc_reg_r;
  logic [PRESC_W-1:0]   presc_cnt_r;
  logic                 done_r;
  logic                 tick_s;
  logic                 terminal_s;

  assign tick_s     = (presc_cnt_r == presc_reg_r);
  // A loaded zero is terminal as well, so the counter never wraps below zero.
  assign terminal_s = (count_r <= {{(WIDTH-1){1'b0}}, 1'b1});

  // Control FSM, counter, prescaler and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= {WIDTH{1'b0}};
      reload_r    <= {WIDTH{1'b0}};
      presc_reg_r <= {PRESC_W{1'b0}};
      presc_cnt_r <= {PRESC_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_valid) begin
            count_r     <= load_value;
            reload_r    <= load_value;
            presc_reg_r <= load_prescale;
            state_r     <= ARMED;
          end
        end
        ARMED: begin
          if (stop) begin
            state_r <= IDLE;
          end else if (start) begin
            state_r     <= RUN;
            presc_cnt_r <= {PRESC_W{1'b0}};
          end
        end
        RUN: begin
          // Stop beats a coincident tick: no decrement and no done that cycle.
          if (stop) begin
            state_r     <= IDLE;
            presc_cnt_r <= {PRESC_W{1'b0}};
          end else if (tick_s) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            if (!terminal_s) begin
              count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
              done_r <= 1'b1;
              if (reload_en) begin
                count_r <= reload_r;
              end else begin
                count_r <= {WIDTH{1'b0}};
                state_r <= IDLE;
              end
            end
          end else begin
            presc_cnt_r <= presc_cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= IDLE;
          presc_cnt_r <= {PRESC_W{1'b0}};
        end
      endcase
    end
  end

  assign load_ready = (state_r == IDLE);
  assign armed      = (state_r == ARMED);
  assign busy       = (state_r == RUN);
  assign count      = count_r;
  assign done       = done_r;

endmodule
